counter_rr_arbiter: RTL

- Shares one increment engine between NUM_CH requesters. Each requester owns a CNT_W-bit counter register held inside this block.
- A round-robin arbiter picks one requester at a time. The winner is granted for one cycle, and its counter is advanced modulo MAX_COUNT.
- Sits between the channel logic that issues count requests and the parallel counter outputs observed by monitors and testbenches.

---
 rtl/counter_rr_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/counter_rr_arbiter.sv
// rtl/counter_rr_arbiter.sv - round-robin arbiter sharing one incrementer among NUM_CH counters
// Optional: COUNTER_RR_ARBITER_SATURATE_EN makes counters saturate at MAX_COUNT-1.
module counter_rr_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 4,
  parameter int MAX_COUNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  output logic [NUM_CH-1:0]       grant,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       wrap,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [CNT_W:0] MAX_V = (CNT_W+1)'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_served;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  pick;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W:0]    inc;
  logic [CNT_W-1:0]  nxt;
  logic              nxt_wrap;

  // First requester strictly after last_served, searching upward with wrap-around.
  always_comb begin
    int idx;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_served) + k) % NUM_CH;
      if (!pick_valid && req[idx]) begin
        pick       = IDX_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  // Incrementer is one bit wider so MAX_COUNT == 2**CNT_W compares correctly.
  always_comb begin
    inc      = {1'b0, cnt[winner]} + (CNT_W+1)'(1);
    nxt      = inc[CNT_W-1:0];
    nxt_wrap = 1'b0;
    if (inc == MAX_V) begin
      nxt_wrap = 1'b1;
`ifdef COUNTER_RR_ARBITER_SATURATE_EN
      nxt      = cnt[winner];
`else
      nxt      = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = SERVE;
      SERVE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      grant       <= '0;
      done        <= '0;
      wrap        <= '0;
      winner      <= '0;
      last_served <= IDX_W'(NUM_CH-1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner <= pick;
            grant  <= NUM_CH'(1) << pick;
          end
        end
        SERVE: begin
          cnt[winner] <= nxt;
          done        <= NUM_CH'(1) << winner;
          wrap        <= nxt_wrap ? (NUM_CH'(1) << winner) : '0;
          grant       <= '0;
          last_served <= winner;
        end
        DONE: begin
          done <= '0;
          wrap <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_flat
    assign counts[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule
